// File: rtl/dram_pattern_tester_pkg.sv
// Shared types and data patterns for the DRAM pattern tester.
// pattern_word builds one bus word from a 128-bit pattern, optionally XORed with the word address.
package dram_test_pkg;

  localparam int PKG_WORD_SIZE = 256;
  localparam int NUM_PATTERNS  = 9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_INIT,
    ST_WRITE,
    ST_WAIT_WRITE,
    ST_READ,
    ST_WAIT_READ,
    ST_CHECK,
    ST_NEXT,
    ST_DONE
  } test_state_t;

  localparam logic [127:0] PAT_0 = {16{8'hA5}};
  localparam logic [127:0] PAT_1 = {16{8'h5A}};
  localparam logic [127:0] PAT_2 = {16{8'hFF}};
  localparam logic [127:0] PAT_3 = {16{8'h00}};
  localparam logic [127:0] PAT_4 = {16{8'hF0}};
  localparam logic [127:0] PAT_5 = {16{8'h0F}};
  localparam logic [127:0] PAT_6 = {16{8'hAA}};
  localparam logic [127:0] PAT_7 = {16{8'h55}};
  localparam logic [127:0] PAT_8 = 128'hAABB_CCDD_EEFF_0011_2233_4455_6677_8899;

  function automatic logic [PKG_WORD_SIZE-1:0] pattern_word(input logic [3:0]  idx,
                                                            input logic [31:0] addr,
                                                            input logic        addr_xor);
    logic [127:0]             pat;
    logic [PKG_WORD_SIZE-1:0] word;
    case (idx)
      4'd0:    pat = PAT_0;
      4'd1:    pat = PAT_1;
      4'd2:    pat = PAT_2;
      4'd3:    pat = PAT_3;
      4'd4:    pat = PAT_4;
      4'd5:    pat = PAT_5;
      4'd6:    pat = PAT_6;
      4'd7:    pat = PAT_7;
      default: pat = PAT_8;
    endcase
    word = {(PKG_WORD_SIZE/128){pat}};
    if (addr_xor) begin
      word = word ^ {(PKG_WORD_SIZE/32){addr}};
    end
    return word;
  endfunction

endpackage

// File: rtl/dram_pattern_tester_if.sv
// Wishbone bus between the pattern tester (master) and the LiteDRAM user port (slave).
interface dram_pattern_tester_if #(
  parameter int WORD_SIZE  = 256,
  parameter int ADDR_WIDTH = 25
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   adr;
  logic [WORD_SIZE-1:0]    dat_w;
  logic [WORD_SIZE/8-1:0]  sel;
  logic [WORD_SIZE-1:0]    dat_r;
  logic                    ack;
  logic                    err;

  modport master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack, err);
  modport slave  (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);
endinterface

// File: rtl/dram_pattern_tester.sv
// Post-calibration DRAM tester: writes nine patterns over a window, reads them back and compares,
// reporting pass/fail, a saturating error count and the first failing location.
module dram_pattern_tester
  import dram_test_pkg::*;
#(
  parameter int WORD_SIZE      = 256,
  parameter int ADDR_WIDTH     = 25,
  parameter int NUM_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ADDR_XOR       = 1
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   init_done_i,
  input  logic                   init_error_i,
  dram_pattern_tester_if.master  wb,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   fail_o,
  output logic                   timeout_o,
  output logic [15:0]            error_count_o,
  output logic [ADDR_WIDTH-1:0]  fail_addr_o,
  output logic [3:0]             fail_pattern_o,
  output logic [7:0]             led_o
);

  localparam int                    TMO_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [3:0]            LAST_PAT  = 4'(NUM_PATTERNS - 1);

  test_state_t           state_q;
  logic [3:0]            pat_idx_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  cyc_q, stb_q, we_q;
  logic [WORD_SIZE-1:0]  dat_w_q;
  logic [WORD_SIZE-1:0]  rdata_q;
  logic                  rd_err_q;
  logic [TMO_W-1:0]      tmo_cnt_q;
  logic                  busy_q, done_q, pass_q, fail_q, timeout_q, init_done_q;
  logic [15:0]           err_cnt_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [3:0]            fail_pat_q;

  logic [WORD_SIZE-1:0]  exp_word_d;
  logic [15:0]           err_cnt_d;
  logic                  log_err_d;
  logic                  bus_done_d;

  assign exp_word_d = WORD_SIZE'(pattern_word(pat_idx_q, 32'(addr_q), ADDR_XOR != 0));
  assign err_cnt_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
  assign bus_done_d = wb.ack | wb.err;

  // A write err and a failed read check are the only two sources of counted errors.
  always_comb begin
    log_err_d = 1'b0;
    if (state_q == ST_WAIT_WRITE) begin
      log_err_d = wb.err;
    end else if (state_q == ST_CHECK) begin
      log_err_d = rd_err_q || (rdata_q != exp_word_d);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pat_idx_q   <= '0;
      addr_q      <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      dat_w_q     <= '0;
      rdata_q     <= '0;
      rd_err_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      init_done_q <= 1'b0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_pat_q  <= '0;
    end else begin
      init_done_q <= init_done_i;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            fail_pat_q  <= '0;
            pat_idx_q   <= '0;
            addr_q      <= '0;
            state_q     <= ST_WAIT_INIT;
          end
        end
        default: begin
          if (init_error_i) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0 | 1'b1;
            pass_q  <= 1'b0;
            fail_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            if (log_err_d) begin
              err_cnt_q <= err_cnt_d;
              if (err_cnt_q == 16'd0) begin
                fail_addr_q <= addr_q;
                fail_pat_q  <= pat_idx_q;
              end
            end
            case (state_q)
              ST_WAIT_INIT: begin
                if (init_done_i) state_q <= ST_WRITE;
              end
              ST_WRITE, ST_READ: begin
                cyc_q     <= 1'b1;
                stb_q     <= 1'b1;
                we_q      <= (state_q == ST_WRITE);
                dat_w_q   <= exp_word_d;
                tmo_cnt_q <= '0;
                state_q   <= (state_q == ST_WRITE) ? ST_WAIT_WRITE : ST_WAIT_READ;
              end
              ST_WAIT_WRITE, ST_WAIT_READ: begin
                // Ack/err is checked before expiry so a response on the last cycle still wins.
                if (bus_done_d) begin
                  cyc_q <= 1'b0;
                  stb_q <= 1'b0;
                  we_q  <= 1'b0;
                  if (state_q == ST_WAIT_READ) begin
                    rdata_q  <= wb.dat_r;
                    rd_err_q <= wb.err;
                    state_q  <= ST_CHECK;
                  end else if (addr_q == LAST_ADDR) begin
                    addr_q  <= '0;
                    state_q <= ST_READ;
                  end else begin
                    addr_q  <= addr_q + ADDR_WIDTH'(1);
                    state_q <= ST_WRITE;
                  end
                end else if (tmo_cnt_q == TMO_LAST) begin
                  cyc_q     <= 1'b0;
                  stb_q     <= 1'b0;
                  we_q      <= 1'b0;
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  pass_q    <= 1'b0;
                  fail_q    <= 1'b1;
                  state_q   <= ST_DONE;
                end else begin
                  tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                end
              end
              ST_CHECK: begin
                if (addr_q == LAST_ADDR) begin
                  addr_q  <= '0;
                  state_q <= ST_NEXT;
                end else begin
                  addr_q  <= addr_q + ADDR_WIDTH'(1);
                  state_q <= ST_READ;
                end
              end
              ST_NEXT: begin
                if (pat_idx_q == LAST_PAT) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_cnt_q == 16'd0);
                  fail_q  <= (err_cnt_q != 16'd0);
                  state_q <= ST_DONE;
                end else begin
                  pat_idx_q <= pat_idx_q + 4'd1;
                  state_q   <= ST_WRITE;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign wb.cyc   = cyc_q;
  assign wb.stb   = stb_q;
  assign wb.we    = we_q;
  assign wb.adr   = addr_q;
  assign wb.dat_w = dat_w_q;
  assign wb.sel   = {(WORD_SIZE/8){cyc_q}};

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;
  assign timeout_o      = timeout_q;
  assign error_count_o  = err_cnt_q;
  assign fail_addr_o    = fail_addr_q;
  assign fail_pattern_o = fail_pat_q;
  assign led_o          = {pat_idx_q, init_done_q, fail_q, pass_q, busy_q};

endmodule

// File: tb/tb_dram_pattern_tester.sv
// Self-checking bench: a Wishbone memory model with fault injection drives the tester through
// table vectors, randomized fault sets scored by a reference model, and timing corner cases.
module tb_dram_pattern_tester;

  localparam int WS    = 256;
  localparam int AW    = 25;
  localparam int NW    = 4;
  localparam int TMO   = 16;
  localparam int NPAT  = 9;
  localparam int NIDX  = NPAT * NW;
  localparam int NXFER = 2 * NIDX;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          init_done_i = 1'b1;
  logic          init_error_i = 1'b0;
  logic          busy_o, done_o, pass_o, fail_o, timeout_o;
  logic [15:0]   error_count_o;
  logic [AW-1:0] fail_addr_o;
  logic [3:0]    fail_pattern_o;
  logic [7:0]    led_o;

  dram_pattern_tester_if #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) wb ();

  dram_pattern_tester #(
    .WORD_SIZE(WS), .ADDR_WIDTH(AW), .NUM_WORDS(NW), .TIMEOUT_CYCLES(TMO), .ADDR_XOR(1)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start_i(start_i),
    .init_done_i(init_done_i), .init_error_i(init_error_i), .wb(wb),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o),
    .timeout_o(timeout_o), .error_count_o(error_count_o), .fail_addr_o(fail_addr_o),
    .fail_pattern_o(fail_pattern_o), .led_o(led_o)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;

  logic [NIDX-1:0] wrErrMask = '0, rdErrMask = '0, corruptMask = '0;
  bit              noAck = 1'b0, latRand = 1'b0, respDone = 1'b0;
  int              fixedDelay = -1, curDelay = 0, waitCnt = 0;
  int              wrCount = 0, rdCount = 0;
  logic [WS-1:0]   mem [NW];
  logic [WS-1:0]   capP0A2 = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkWord(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference word built byte by byte: pattern byte XOR the matching byte of the 32-bit address.
  function automatic logic [WS-1:0] refWord(input int p, input int a);
    logic [127:0] big;
    logic [31:0]  a32;
    logic [7:0]   b;
    logic [WS-1:0] w;
    big = 128'hAABB_CCDD_EEFF_0011_2233_4455_6677_8899;
    a32 = a;
    w = '0;
    for (int i = 0; i < WS / 8; i++) begin
      case (p)
        0: b = 8'hA5;
        1: b = 8'h5A;
        2: b = 8'hFF;
        3: b = 8'h00;
        4: b = 8'hF0;
        5: b = 8'h0F;
        6: b = 8'hAA;
        7: b = 8'h55;
        default: b = big[8*(i%16) +: 8];
      endcase
      b = b ^ a32[8*(i%4) +: 8];
      w[8*i +: 8] = b;
    end
    return w;
  endfunction

  // Errors in time order: per pattern, all writes then all reads.
  task automatic refExpect(input logic [NIDX-1:0] we_, input logic [NIDX-1:0] re_,
                           input logic [NIDX-1:0] co_, output int cnt, output int fa, output int fp);
    bit found = 0;
    cnt = 0; fa = 0; fp = 0;
    for (int p = 0; p < NPAT; p++) begin
      for (int a = 0; a < NW; a++) begin
        if (we_[p*NW+a]) begin
          cnt++;
          if (!found) begin fa = a; fp = p; found = 1; end
        end
      end
      for (int a = 0; a < NW; a++) begin
        if (re_[p*NW+a] || co_[p*NW+a]) begin
          cnt++;
          if (!found) begin fa = a; fp = p; found = 1; end
        end
      end
    end
  endtask

  always @(negedge sys_clk) begin
    wb.ack = 1'b0;
    wb.err = 1'b0;
    if (!(wb.cyc && wb.stb)) begin
      respDone = 1'b0;
      waitCnt  = 0;
      curDelay = (fixedDelay >= 0) ? fixedDelay : (latRand ? int'($urandom_range(0, 3)) : 0);
    end else if (!respDone && !noAck) begin
      if (waitCnt < curDelay) begin
        waitCnt++;
      end else begin
        respDone = 1'b1;
        if (wb.we) begin
          checkOutput("wr_adr", 64'(wb.adr), 64'(wrCount % NW));
          checkOutput("wr_sel", 64'(wb.sel), 64'(32'hFFFF_FFFF));
          checkWord("wr_data", wb.dat_w, refWord(wrCount / NW, wrCount % NW));
          mem[int'(wb.adr) % NW] = wb.dat_w;
          if (wrCount == 2) capP0A2 = wb.dat_w;
          if (wrCount < NIDX && wrErrMask[wrCount]) wb.err = 1'b1;
          else wb.ack = 1'b1;
          wrCount++;
        end else begin
          checkOutput("rd_adr", 64'(wb.adr), 64'(rdCount % NW));
          wb.dat_r = mem[int'(wb.adr) % NW];
          if (rdCount < NIDX && corruptMask[rdCount]) wb.dat_r[0] = ~wb.dat_r[0];
          if (rdCount < NIDX && rdErrMask[rdCount]) wb.err = 1'b1;
          else wb.ack = 1'b1;
          rdCount++;
        end
      end
    end
  end

  task automatic startRun();
    wrCount = 0;
    rdCount = 0;
    @(negedge sys_clk);
    start_i = 1'b1;
    @(negedge sys_clk);
    start_i = 1'b0;
  endtask

  task automatic waitDone(input int bound);
    int n = 0;
    while (!done_o && n < bound) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("done_wait", 64'(done_o), 64'd1);
  endtask

  task automatic applyStimulus(input logic [NIDX-1:0] w, input logic [NIDX-1:0] r,
                               input logic [NIDX-1:0] c);
    wrErrMask = w;
    rdErrMask = r;
    corruptMask = c;
    startRun();
    waitDone(6000);
  endtask

  task automatic checkRun(input string nm, input int expCnt, input bit expPass,
                          input int expAddr, input int expPat);
    checkOutput({nm, ".busy"}, 64'(busy_o), 64'd0);
    checkOutput({nm, ".pass"}, 64'(pass_o), 64'(expPass));
    checkOutput({nm, ".fail"}, 64'(fail_o), 64'(!expPass));
    checkOutput({nm, ".timeout"}, 64'(timeout_o), 64'd0);
    checkOutput({nm, ".count"}, 64'(error_count_o), 64'(expCnt));
    checkOutput({nm, ".faddr"}, 64'(fail_addr_o), 64'(expAddr));
    checkOutput({nm, ".fpat"}, 64'(fail_pattern_o), 64'(expPat));
    checkOutput({nm, ".led"}, 64'(led_o), 64'({4'd8, 1'b1, !expPass, expPass, 1'b0}));
    checkOutput({nm, ".xfers"}, 64'(wrCount + rdCount), 64'(NXFER));
  endtask

  typedef struct {
    string           name;
    logic [NIDX-1:0] wrErr;
    logic [NIDX-1:0] rdErr;
    logic [NIDX-1:0] corrupt;
    int              expCnt;
    bit              expPass;
    int              expAddr;
    int              expPat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int n, rc, ra, rp;
    logic [NIDX-1:0] rw, rr, rcm;

    vecs[0] = '{"clean",      36'h0,         36'h0,    36'h0,         0,  1'b1, 0, 0};
    vecs[1] = '{"bitflip",    36'h0,         36'h0,    36'h0_0008_0000, 1, 1'b0, 3, 4};
    vecs[2] = '{"rderr_p0",   36'h0,         36'hF,    36'h0,         4,  1'b0, 0, 0};
    vecs[3] = '{"wrerr",      36'h0_0000_0200, 36'h0,  36'h8_0000_0000, 2, 1'b0, 1, 2};
    vecs[4] = '{"err_and_flip", 36'h0,       36'h40,   36'h40,        1,  1'b0, 2, 1};
    vecs[5] = '{"all_flip",   36'h0,         36'h0,    36'hF_FFFF_FFFF, 36, 1'b0, 0, 0};
    vecs[6] = '{"wr_after_rd", 36'h0_1000_0000, 36'h4000, 36'h0,     2,  1'b0, 2, 3};

    repeat (3) @(negedge sys_clk);
    checkOutput("rst.busy", 64'(busy_o), 64'd0);
    checkOutput("rst.done", 64'(done_o), 64'd0);
    checkOutput("rst.led", 64'(led_o), 64'd0);
    checkOutput("rst.count", 64'(error_count_o), 64'd0);
    checkOutput("rst.cyc_stb", 64'({wb.cyc, wb.stb, wb.we}), 64'd0);
    checkOutput("rst.sel", 64'(wb.sel), 64'd0);
    rst_n = 1'b1;
    @(negedge sys_clk);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].wrErr, vecs[i].rdErr, vecs[i].corrupt);
      checkRun(vecs[i].name, vecs[i].expCnt, vecs[i].expPass, vecs[i].expAddr, vecs[i].expPat);
      if (i == 0) checkWord("p0_a2_word", capP0A2, {32{8'hA5}} ^ {8{32'h2}});
    end

    latRand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NIDX; i++) begin
        rw[i]  = ($urandom_range(0, 23) == 0);
        rr[i]  = ($urandom_range(0, 15) == 0);
        rcm[i] = ($urandom_range(0, 15) == 0);
      end
      refExpect(rw, rr, rcm, rc, ra, rp);
      applyStimulus(rw, rr, rcm);
      checkRun("random", rc, rc == 0, ra, rp);
    end
    latRand = 1'b0;

    // Every response lands on the last cycle before expiry.
    fixedDelay = TMO - 1;
    applyStimulus('0, '0, '0);
    checkRun("ack_at_expiry", 0, 1'b1, 0, 0);
    fixedDelay = -1;

    noAck = 1'b1;
    startRun();
    n = 0;
    while (!wb.stb && n < 20) begin @(negedge sys_clk); n++; end
    checkOutput("tmo.stb_rise", 64'(wb.stb), 64'd1);
    n = 0;
    while (wb.cyc && n < 40) begin n++; @(negedge sys_clk); end
    checkOutput("tmo.cyc_window", 64'(n >= TMO && n <= TMO + 1), 64'd1);
    waitDone(10);
    checkOutput("tmo.flags", 64'({timeout_o, fail_o, pass_o, busy_o}), 64'b1100);
    checkOutput("tmo.led", 64'(led_o), 64'h0C);
    noAck = 1'b0;

    init_done_i = 1'b0;
    startRun();
    repeat (3) @(negedge sys_clk);
    checkOutput("ie.busy", 64'(busy_o), 64'd1);
    start_i = 1'b1;
    @(negedge sys_clk);
    start_i = 1'b0;
    repeat (2) @(negedge sys_clk);
    checkOutput("ie.still_waiting", 64'({busy_o, done_o, wb.cyc}), 64'b100);
    init_error_i = 1'b1;
    @(negedge sys_clk);
    init_error_i = 1'b0;
    waitDone(10);
    checkOutput("ie.flags", 64'({fail_o, pass_o, timeout_o, busy_o}), 64'b1000);
    checkOutput("ie.count", 64'(error_count_o), 64'd0);
    checkOutput("ie.led", 64'(led_o), 64'h04);
    checkOutput("ie.no_bus", 64'(wrCount + rdCount), 64'd0);
    init_done_i = 1'b1;

    fixedDelay = 10;
    startRun();
    n = 0;
    while (!(wb.cyc && !wb.we) && n < 1000) begin @(negedge sys_clk); n++; end
    checkOutput("rstmid.in_read", 64'({wb.cyc, wb.we}), 64'b10);
    repeat (3) @(negedge sys_clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstmid.async", 64'({wb.cyc, wb.stb, busy_o}), 64'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    fixedDelay = -1;
    @(negedge sys_clk);
    applyStimulus('0, '0, '0);
    checkRun("after_reset", 0, 1'b1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
